// File: rtl/dac_pkg.sv
//------------------------------------------------------------------------------
// Module   : dac_pkg
// Brief    : Shared defaults, input-format enum and midscale helper for the
//            segmented DAC encoder.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package dac_pkg;

  localparam int DEF_DW    = 10;
  localparam int DEF_BIN_W = 7;
  localparam int DEF_DIV   = 4;
  localparam int DEF_DEPTH = 4;

  typedef enum logic {
    OFFSET = 1'b0,
    TWOS   = 1'b1
  } fmt_e;

  // Offset-binary midscale: only the top bit of a DW-wide code set.
  function automatic logic [31:0] midscale_code(input int unsigned dw);
    return 32'd1 << (dw - 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/dac_sample_fifo.sv
//------------------------------------------------------------------------------
// Module   : dac_sample_fifo
// Brief    : Power-of-two sample FIFO with synchronous flush and occupancy out.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module dac_sample_fifo
  import dac_pkg::*;
#(
  parameter int DW    = DEF_DW,
  parameter int DEPTH = DEF_DEPTH,
  localparam int AW   = $clog2(DEPTH),
  localparam int LW   = AW + 1
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_flush,
  input  logic          i_push,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_pop,
  output logic [DW-1:0] o_rdata,
  output logic          o_full,
  output logic          o_empty,
  output logic [LW-1:0] o_level
);

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [LW-1:0] r_level;
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_level == LW'(DEPTH));
  assign o_empty = (r_level == '0);
  assign o_level = r_level;
  assign o_rdata = r_mem[r_rptr];

  assign w_push = i_push && !o_full;
  assign w_pop  = i_pop && !o_empty;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else if (i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push && !i_flush) r_mem[r_wptr] <= i_wdata;
  end

endmodule

`default_nettype wire

// File: rtl/dac_seg_encoder.sv
//------------------------------------------------------------------------------
// Module   : dac_seg_encoder
// Brief    : Buffered segmented DAC encoder: binary LSB lines plus thermometer
//            MSB lines with optional data-weighted-averaging rotation.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module dac_seg_encoder
  import dac_pkg::*;
#(
  parameter int DW     = DEF_DW,
  parameter int BIN_W  = DEF_BIN_W,
  parameter int DIV    = DEF_DIV,
  parameter int DEPTH  = DEF_DEPTH,
  localparam int MSB_W  = DW - BIN_W,
  localparam int NTHERM = 2**MSB_W - 1,
  localparam int LW     = $clog2(DEPTH) + 1
) (
  input  logic              clkin,
  input  logic              rstb,
  input  logic              pdb,
  input  logic [DW-1:0]     in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              fmt_twos,
  input  logic              dem_en,
  input  logic              clear_flags,
  output logic [BIN_W-1:0]  datainbin,
  output logic [BIN_W-1:0]  datainbinb,
  output logic [NTHERM-1:0] dataintherm,
  output logic [NTHERM-1:0] datainthermb,
  output logic              underflow,
  output logic [LW-1:0]     fifo_level
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int PW = MSB_W + 1;

  // Lines p..p+k-1 (mod NTHERM) are set: line i is on when its distance
  // from p, walking upward with wrap, is below k.
  function automatic logic [NTHERM-1:0] f_therm(input logic [MSB_W-1:0] k,
                                                input logic [MSB_W-1:0] p);
    logic [NTHERM-1:0] m;
    logic [PW-1:0]     d;
    m = '0;
    for (int i = 0; i < NTHERM; i++) begin
      d = PW'(i) + PW'(NTHERM) - {1'b0, p};
      if (d >= PW'(NTHERM)) d = d - PW'(NTHERM);
      m[i] = (d < {1'b0, k});
    end
    return m;
  endfunction

  localparam logic [DW-1:0]     c_MID_CODE  = DW'(midscale_code(DW));
  localparam logic [BIN_W-1:0]  c_MID_BIN   = c_MID_CODE[BIN_W-1:0];
  localparam logic [MSB_W-1:0]  c_MID_K     = c_MID_CODE[DW-1:BIN_W];
  localparam logic [NTHERM-1:0] c_MID_THERM = f_therm(c_MID_K, MSB_W'(0));

  logic [CW-1:0]     r_cnt;
  logic [MSB_W-1:0]  r_p;
  logic              r_uf;
  logic [NTHERM-1:0] r_therm;
  logic [BIN_W-1:0]  r_bin;

  logic              w_full;
  logic              w_empty;
  logic [DW-1:0]     w_head;
  logic              w_in_ready;
  logic              w_push;
  logic              w_strobe;
  logic              w_pop;
  logic [DW-1:0]     w_code;
  logic [MSB_W-1:0]  w_k;
  logic [MSB_W-1:0]  w_p_eff;
  logic [NTHERM-1:0] w_therm_next;
  logic [PW-1:0]     w_p_sum;
  logic [MSB_W-1:0]  w_p_next;

  assign w_in_ready = rstb && pdb && !w_full;
  assign w_push     = in_valid && w_in_ready;
  assign w_strobe   = pdb && (r_cnt == CW'(DIV - 1));
  assign w_pop      = w_strobe && !w_empty;

  dac_sample_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (clkin),
    .i_rst_n (rstb),
    .i_flush (!pdb),
    .i_push  (w_push),
    .i_wdata (in_data),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (fifo_level)
  );

  always_comb begin
    w_code = w_head;
    if (fmt_e'(fmt_twos) == TWOS) w_code[DW-1] = ~w_head[DW-1];
  end

  assign w_k          = w_code[DW-1:BIN_W];
  assign w_p_eff      = dem_en ? r_p : '0;
  assign w_therm_next = f_therm(w_k, w_p_eff);
  assign w_p_sum      = {1'b0, r_p} + {1'b0, w_k};
  assign w_p_next     = (w_p_sum >= PW'(NTHERM)) ? MSB_W'(w_p_sum - PW'(NTHERM))
                                                 : MSB_W'(w_p_sum);

  always_ff @(posedge clkin or negedge rstb) begin
    if (!rstb) begin
      r_cnt   <= '0;
      r_p     <= '0;
      r_uf    <= 1'b0;
      r_therm <= c_MID_THERM;
      r_bin   <= c_MID_BIN;
    end else begin
      if (w_strobe && w_empty) r_uf <= 1'b1;
      else if (clear_flags)    r_uf <= 1'b0;

      if (!pdb) begin
        r_cnt   <= '0;
        r_p     <= '0;
        r_therm <= c_MID_THERM;
        r_bin   <= c_MID_BIN;
      end else begin
        r_cnt <= w_strobe ? '0 : r_cnt + CW'(1);
        if (w_pop) begin
          r_therm <= w_therm_next;
          r_bin   <= w_code[BIN_W-1:0];
          if (dem_en) r_p <= w_p_next;
        end
        // Leaving rotation mode restarts the pointer at line 0.
        if (!dem_en) r_p <= '0;
      end
    end
  end

  assign in_ready     = w_in_ready;
  assign underflow    = r_uf;
  assign dataintherm  = r_therm;
  assign datainthermb = ~r_therm;
  assign datainbin    = r_bin;
  assign datainbinb   = ~r_bin;

endmodule

`default_nettype wire

// File: tb/tb_dac_seg_encoder.sv
//------------------------------------------------------------------------------
// Module   : tb_dac_seg_encoder
// Brief    : Scoreboard bench for dac_seg_encoder with directed sample vectors.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_dac_seg_encoder;

  localparam int DW     = 10;
  localparam int BIN_W  = 7;
  localparam int DIV    = 8;
  localparam int DEPTH  = 4;
  localparam int NTHERM = 7;
  localparam int LW     = 3;

  typedef struct packed {
    logic [NTHERM-1:0] therm;
    logic [BIN_W-1:0]  bin;
  } exp_t;

  localparam exp_t c_MID = {7'h0F, 7'h00};

  logic              clk = 1'b0;
  logic              rstb = 1'b0;
  logic              pdb = 1'b1;
  logic [DW-1:0]     in_data = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic              fmt_twos = 1'b0;
  logic              dem_en = 1'b0;
  logic              clear_flags = 1'b0;
  logic [BIN_W-1:0]  datainbin;
  logic [BIN_W-1:0]  datainbinb;
  logic [NTHERM-1:0] dataintherm;
  logic [NTHERM-1:0] datainthermb;
  logic              underflow;
  logic [LW-1:0]     fifo_level;

  int   checks = 0;
  int   errors = 0;
  int   tb_cnt = 0;
  exp_t q[$];
  exp_t exp_last = c_MID;

  always #5 clk = ~clk;

  dac_seg_encoder #(
    .DW    (DW),
    .BIN_W (BIN_W),
    .DIV   (DIV),
    .DEPTH (DEPTH)
  ) dut (
    .clkin        (clk),
    .rstb         (rstb),
    .pdb          (pdb),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .fmt_twos     (fmt_twos),
    .dem_en       (dem_en),
    .clear_flags  (clear_flags),
    .datainbin    (datainbin),
    .datainbinb   (datainbinb),
    .dataintherm  (dataintherm),
    .datainthermb (datainthermb),
    .underflow    (underflow),
    .fifo_level   (fifo_level)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, req);
    end
  endtask

  // Monitor: tracks the update strobe from reset/power-down release and
  // compares the registered outputs one cycle after each strobe.
  initial begin
    logic do_cmp;
    logic do_pop;
    forever begin
      @(posedge clk);
      do_cmp = 1'b0;
      do_pop = 1'b0;
      if (!rstb || !pdb) begin
        tb_cnt   = 0;
        exp_last = c_MID;
      end else if (tb_cnt == DIV - 1) begin
        do_cmp = 1'b1;
        do_pop = (q.size() > 0);
        tb_cnt = 0;
      end else begin
        tb_cnt++;
      end
      @(negedge clk);
      if (do_cmp) begin
        if (do_pop) exp_last = q.pop_front();
        check("therm", 32'(dataintherm), 32'(exp_last.therm));
        check("bin",   32'(datainbin),   32'(exp_last.bin));
        check("thermb_inv", 32'(datainthermb ^ exp_last.therm), 32'h7F);
        check("binb_inv",   32'(datainbinb ^ exp_last.bin),     32'h7F);
      end
    end
  end

  task automatic push(input logic [DW-1:0] d, input logic [NTHERM-1:0] et,
                      input logic [BIN_W-1:0] eb);
    int   n;
    logic acc;
    exp_t e;
    n = 0;
    acc = 1'b0;
    in_data  = d;
    in_valid = 1'b1;
    while (!acc && n < 200) begin
      acc = in_ready;
      @(negedge clk);
      n++;
    end
    in_valid = 1'b0;
    check("push_accept", 32'(acc), 32'd1);
    if (acc) begin
      e.therm = et;
      e.bin   = eb;
      q.push_back(e);
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (q.size() > 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("drain", 32'(q.size()), 32'd0);
  endtask

  task automatic wait_cnt(input int c);
    int n;
    n = 0;
    while (tb_cnt != c && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("align", 32'(tb_cnt), 32'(c));
  endtask

  task automatic check_mid(input string tag);
    check({tag, "_therm"},  32'(dataintherm),  32'h0F);
    check({tag, "_thermb"}, 32'(datainthermb), 32'h70);
    check({tag, "_bin"},    32'(datainbin),    32'h00);
    check({tag, "_binb"},   32'(datainbinb),   32'h7F);
    check({tag, "_level"},  32'(fifo_level),   32'd0);
    check({tag, "_ready"},  32'(in_ready),     32'd0);
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check_mid("rst");
    check("rst_uf", 32'(underflow), 32'd0);
    rstb = 1'b1;
    @(negedge clk);
    check("rel_ready", 32'(in_ready), 32'd1);
    check("rel_uf", 32'(underflow), 32'd0);
    check("rel_therm", 32'(dataintherm), 32'h0F);

    // Offset binary, no rotation
    push(10'h3FF, 7'h7F, 7'h7F);
    push(10'h0A5, 7'h01, 7'h25);
    push(10'h155, 7'h03, 7'h55);
    wait_drain();

    // Underflow is sticky; a same-cycle set beats clear_flags
    repeat (2 * DIV) @(negedge clk);
    check("uf_set", 32'(underflow), 32'd1);
    wait_cnt(2);
    clear_flags = 1'b1;
    @(negedge clk);
    clear_flags = 1'b0;
    check("uf_clear", 32'(underflow), 32'd0);
    wait_cnt(DIV - 1);
    clear_flags = 1'b1;
    @(negedge clk);
    clear_flags = 1'b0;
    check("uf_setwins", 32'(underflow), 32'd1);
    wait_cnt(2);
    clear_flags = 1'b1;
    @(negedge clk);
    clear_flags = 1'b0;
    check("uf_clear2", 32'(underflow), 32'd0);

    // Rotation: k=3 three times, then k=0 and k=1 from p=2
    dem_en = 1'b1;
    push(10'h180, 7'h07, 7'h00);
    push(10'h181, 7'h38, 7'h01);
    push(10'h182, 7'h43, 7'h02);
    push(10'h003, 7'h00, 7'h03);
    push(10'h080, 7'h04, 7'h00);
    wait_drain();
    dem_en = 1'b0;
    push(10'h100, 7'h03, 7'h00);
    wait_drain();
    dem_en = 1'b1;
    push(10'h080, 7'h01, 7'h00);
    wait_drain();
    dem_en = 1'b0;

    // Two's complement input
    fmt_twos = 1'b1;
    push(10'h000, 7'h0F, 7'h00);
    push(10'h200, 7'h00, 7'h00);
    push(10'h1FF, 7'h7F, 7'h7F);
    wait_drain();
    fmt_twos = 1'b0;

    // Fill to full between strobes; fifth sample waits for space
    wait_cnt(0);
    push(10'h001, 7'h00, 7'h01);
    push(10'h002, 7'h00, 7'h02);
    push(10'h003, 7'h00, 7'h03);
    push(10'h004, 7'h00, 7'h04);
    check("full_level", 32'(fifo_level), 32'd4);
    check("full_ready", 32'(in_ready), 32'd0);
    push(10'h005, 7'h00, 7'h05);
    wait_drain();

    // Power-down mid-stream
    push(10'h3FF, 7'h7F, 7'h7F);
    push(10'h155, 7'h03, 7'h55);
    pdb = 1'b0;
    @(negedge clk);
    q.delete();
    check_mid("pd");
    @(negedge clk);
    pdb = 1'b1;
    push(10'h0A5, 7'h01, 7'h25);
    wait_drain();

    // Asynchronous reset mid-stream
    push(10'h3FF, 7'h7F, 7'h7F);
    push(10'h0A5, 7'h01, 7'h25);
    #2 rstb = 1'b0;
    #1;
    q.delete();
    check_mid("arst");
    check("arst_uf", 32'(underflow), 32'd0);
    repeat (2) @(negedge clk);
    rstb = 1'b1;
    push(10'h155, 7'h03, 7'h55);
    wait_drain();

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/dac_seg_encoder.md
DAC_SEG_ENCODER -- requirements
Module: dac_seg_encoder

Interface
REQ-001 SHALL have parameter DW, default 10, total sample width.
REQ-002 SHALL have parameter BIN_W, default 7, LSBs driven as binary-weighted lines.
REQ-003 SHALL have parameter DIV, default 4, clkin cycles per output update, legal range >=1.
REQ-004 SHALL have parameter DEPTH, default 4, input FIFO entries, power of two, >=2.
REQ-005 SHALL derive MSB_W = DW-BIN_W and NTHERM = 2**MSB_W-1.
REQ-006 SHALL have port clkin, input, 1, sole clock, rising edge.
REQ-007 SHALL have port rstb, input, 1, reset, asynchronous, active-low.
REQ-008 SHALL have port pdb, input, 1, power-down bar, synchronous, active-low.
REQ-009 SHALL have port in_data, input, DW, sample code.
REQ-010 SHALL have port in_valid, input, 1, sample offered.
REQ-011 SHALL have port in_ready, output, 1, FIFO can accept.
REQ-012 SHALL have port fmt_twos, input, 1, 1 = in_data is two's complement, 0 = offset binary.
REQ-013 SHALL have port dem_en, input, 1, 1 = data-weighted-averaging rotation of thermometer lines.
REQ-014 SHALL have port clear_flags, input, 1, clears underflow.
REQ-015 SHALL have ports datainbin and datainbinb, output, BIN_W, binary lines and exact complement.
REQ-016 SHALL have ports dataintherm and datainthermb, output, NTHERM, thermometer lines and exact complement.
REQ-017 SHALL have port underflow, output, 1, sticky empty-at-update flag.
REQ-018 SHALL have port fifo_level, output, $clog2(DEPTH)+1, current occupancy.

Function
REQ-019 SHALL push in_data on in_valid && in_ready; in_ready = !full, no same-cycle pass-through when full.
REQ-020 SHALL run a counter 0..DIV-1, wrapping; update strobe when count == DIV-1.
REQ-021 SHALL on strobe with FIFO non-empty pop head; outputs reflect that sample on the next cycle (latency 1 after strobe).
REQ-022 SHALL, in two's-complement mode, convert to offset by inverting in_data[DW-1] before encoding.
REQ-023 SHALL encode k = code[DW-1:BIN_W] as k thermometer lines set and code[BIN_W-1:0] directly on datainbin.
REQ-024 SHALL with dem_en=0 set lines 0..k-1 and hold rotation pointer p at 0.
REQ-025 SHALL with dem_en=1 set lines p..p+k-1 modulo NTHERM, then p <= (p+k) mod NTHERM; k=0 leaves p unchanged.
REQ-026 SHALL clear p to 0 on the cycle dem_en falls.
REQ-027 SHALL on strobe with FIFO empty hold all outputs and p, set underflow.
REQ-028 SHALL give clear_flags priority below a same-cycle underflow set (set wins).
REQ-029 SHALL keep every *b output the bitwise inverse of its partner on every cycle.
REQ-030 SHALL with pdb=0 flush FIFO, reset counter and p, force midscale (k=2**(MSB_W-1), binary 0); in_ready=0.
REQ-031 SHALL accept a push and pop in the same cycle when neither full nor empty blocks, level unchanged.

Reset
REQ-032 SHALL on rstb=0 immediately force: FIFO empty, fifo_level 0, counter 0, p 0, underflow 0, outputs midscale, in_ready 0 until rstb released.
REQ-033 SHALL tolerate reset mid-stream: no partial sample survives; first update after release follows REQ-020.

Structure
REQ-034 SHALL place default parameters, midscale-code function and a fmt enum (OFFSET, TWOS) in package dac_pkg.
REQ-035 SHALL implement the buffer as sub-module dac_sample_fifo (parametrised DW, DEPTH, level output).
REQ-036 SHALL register all encoder outputs; no combinational path from in_data to any output.

Verification (defaults DW=10, BIN_W=7, NTHERM=7, DIV=4, DEPTH=4)
REQ-037 Reset release -> dataintherm=0001111, datainbin=0, complements inverse, underflow=0.
REQ-038 Push 0x3FF offset, dem_en=0 -> one cycle after strobe therm=1111111, bin=0x7F, both complements 0.
REQ-039 dem_en=1, three samples k=3 -> therm lines {0,1,2}, {3,4,5}, {6,0,1}; p ends at 2.
REQ-040 fmt_twos=1: push 0x000 then 0x200 -> midscale, then therm=0, bin=0.
REQ-041 Five pushes, no strobe in between (DIV large) -> in_ready low after 4, fifo_level=4, fifth held.
REQ-042 Empty FIFO at strobe -> outputs hold, underflow=1 until clear_flags; pdb=0 mid-stream -> midscale next cycle, level 0.
